// File: rtl/divide_pkg.sv
// Shared divider definitions: FSM state encoding and operating-mode constants
// used by all divider variants.
package divide_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam logic MODE_FRAC = 1'b0;
  localparam logic MODE_INT  = 1'b1;

endpackage

// File: rtl/divide_r_iter_if.sv
// Operand/result handshake bundle for the iterative restoring divider.
interface divide_r_iter_if #(
  parameter int unsigned WIDTH = 26
);

  logic             in_valid;
  logic             in_ready;
  logic             mode_int;
  logic [WIDTH-1:0] num;
  logic [WIDTH-1:0] den;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] remo;
  logic             sticky;
  logic             div_zero;
  logic             ovf;

  modport master (
    output in_valid, mode_int, num, den, out_ready,
    input  in_ready, out_valid, quot, remo, sticky, div_zero, ovf
  );

  modport slave (
    input  in_valid, mode_int, num, den, out_ready,
    output in_ready, out_valid, quot, remo, sticky, div_zero, ovf
  );

endinterface

// File: rtl/divide_r_step.sv
// Combinational restoring-division stage: resolves BITS_PER_CYCLE quotient bits,
// MSB first, shifting one dividend bit into the partial remainder per bit.
module divide_r_step #(
  parameter int unsigned WIDTH          = 26,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic [WIDTH:0]          r_i,
  input  logic [WIDTH-1:0]        q_i,
  input  logic [WIDTH:0]          neg_den_i,
  input  logic [WIDTH-1:0]        den_i,
  input  logic [BITS_PER_CYCLE-1:0] nbits_i,
  output logic [WIDTH:0]          r_o,
  output logic [WIDTH-1:0]        q_o
);

  localparam int unsigned XW = WIDTH + 2;

  logic [XW-1:0]  shifted;
  logic [XW-1:0]  trial;
  logic [WIDTH:0] rr;
  logic [WIDTH-1:0] qq;
  logic           take;

  // Trial is one bit wider than r so 2r is never truncated; in range its top
  // bit equals the sign bit t[WIDTH]. A negative trial is restored by adding den back.
  always_comb begin
    rr      = r_i;
    qq      = q_i;
    shifted = '0;
    trial   = '0;
    take    = 1'b0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      shifted = (XW'(rr) << 1) | XW'(nbits_i[BITS_PER_CYCLE-1-i]);
      trial   = shifted + {neg_den_i[WIDTH], neg_den_i};
      take    = ~trial[XW-1];
      rr      = take ? trial[WIDTH:0] : trial[WIDTH:0] + {1'b0, den_i};
      qq      = (qq << 1) | WIDTH'(take);
    end
    r_o = rr;
    q_o = qq;
  end

endmodule

// File: rtl/divide_r_iter.sv
// Iterative unsigned restoring divider with valid/ready handshake, fraction and
// integer modes, and divide-by-zero / fraction-overflow flags.
module divide_r_iter
  import divide_pkg::*;
#(
  parameter int unsigned WIDTH          = 26,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input logic            clk,
  input logic            rst,
  divide_r_iter_if.slave bus
);

  localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N + 1);

  if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("divide_r_iter: BITS_PER_CYCLE must divide WIDTH exactly");
  end

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] num_sh_q, num_sh_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [WIDTH:0]   neg_den_q, neg_den_d;
  logic             mode_q, mode_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             sticky_q, sticky_d;
  logic             div_zero_q, div_zero_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [BITS_PER_CYCLE-1:0] nbits_c;
  logic [WIDTH:0]            r_nx;
  logic [WIDTH-1:0]          q_nx;

  // Fraction mode starts with r0 = num, so no dividend bits are shifted in.
  assign nbits_c = (mode_q == MODE_INT) ? num_sh_q[WIDTH-1 -: BITS_PER_CYCLE] : '0;

  divide_r_step #(
    .WIDTH         (WIDTH),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .r_i      (r_q),
    .q_i      (q_q),
    .neg_den_i(neg_den_q),
    .den_i    (den_q),
    .nbits_i  (nbits_c),
    .r_o      (r_nx),
    .q_o      (q_nx)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    r_d        = r_q;
    q_d        = q_q;
    num_sh_d   = num_sh_q;
    den_d      = den_q;
    neg_den_d  = neg_den_q;
    mode_d     = mode_q;
    ovf_pend_d = ovf_pend_q;
    quot_d     = quot_q;
    remo_d     = remo_q;
    sticky_d   = sticky_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          mode_d     = bus.mode_int;
          den_d      = bus.den;
          neg_den_d  = (WIDTH+1)'(0) - {1'b0, bus.den};
          num_sh_d   = bus.num;
          r_d        = (bus.mode_int == MODE_INT) ? '0 : {1'b0, bus.num};
          q_d        = '0;
          cnt_d      = CW'(N);
          ovf_pend_d = (bus.mode_int == MODE_FRAC) && (bus.num > bus.den);
          if (bus.den == '0) begin
            state_d    = ST_DONE;
            quot_d     = '1;
            remo_d     = bus.num;
            sticky_d   = |bus.num;
            div_zero_d = 1'b1;
            ovf_d      = 1'b0;
          end else begin
            state_d    = ST_RUN;
            quot_d     = '0;
            remo_d     = '0;
            sticky_d   = 1'b0;
            div_zero_d = 1'b0;
            ovf_d      = 1'b0;
          end
        end
      end
      ST_RUN: begin
        r_d      = r_nx;
        q_d      = q_nx;
        num_sh_d = num_sh_q << BITS_PER_CYCLE;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          if (ovf_pend_q) begin
            quot_d   = {1'b0, {(WIDTH-1){1'b1}}};
            remo_d   = '0;
            sticky_d = 1'b1;
            ovf_d    = 1'b1;
          end else begin
            quot_d   = (mode_q == MODE_INT) ? q_nx : (q_nx >> 1);
            remo_d   = r_nx[WIDTH-1:0];
            sticky_d = |r_nx[WIDTH-1:0];
          end
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    out_valid_d = (state_d == ST_DONE);
    in_ready_d  = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      num_sh_q    <= '0;
      den_q       <= '0;
      neg_den_q   <= '0;
      mode_q      <= MODE_FRAC;
      ovf_pend_q  <= 1'b0;
      quot_q      <= '0;
      remo_q      <= '0;
      sticky_q    <= 1'b0;
      div_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      q_q         <= q_d;
      num_sh_q    <= num_sh_d;
      den_q       <= den_d;
      neg_den_q   <= neg_den_d;
      mode_q      <= mode_d;
      ovf_pend_q  <= ovf_pend_d;
      quot_q      <= quot_d;
      remo_q      <= remo_d;
      sticky_q    <= sticky_d;
      div_zero_q  <= div_zero_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quot      = quot_q;
  assign bus.remo      = remo_q;
  assign bus.sticky    = sticky_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_divide_r_iter.sv
// Bench for divide_r_iter: two instances (1 and 2 bits/cycle) driven in lockstep,
// checked against an arithmetic reference model.
module tb_divide_r_iter;

  localparam int unsigned W    = 26;
  localparam int          LAT1 = W / 1 + 1;
  localparam int          LAT2 = W / 2 + 1;

  typedef struct {
    logic [W-1:0] quot;
    logic [W-1:0] remo;
    logic         sticky;
    logic         dz;
    logic         ovf;
  } res_t;

  typedef struct {
    logic         mode;
    logic [W-1:0] num;
    logic [W-1:0] den;
    res_t         exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, mode_int, out_ready;
  logic [W-1:0] num, den;
  int           total = 0;
  int           bad   = 0;

  divide_r_iter_if #(.WIDTH(W)) bus1 ();
  divide_r_iter_if #(.WIDTH(W)) bus2 ();

  assign bus1.in_valid  = in_valid;
  assign bus1.mode_int  = mode_int;
  assign bus1.num       = num;
  assign bus1.den       = den;
  assign bus1.out_ready = out_ready;
  assign bus2.in_valid  = in_valid;
  assign bus2.mode_int  = mode_int;
  assign bus2.num       = num;
  assign bus2.den       = den;
  assign bus2.out_ready = out_ready;

  divide_r_iter #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  divide_r_iter #(.WIDTH(W), .BITS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: quotient/remainder from plain integer arithmetic on the operands.
  function automatic res_t model(input logic m, input logic [W-1:0] n, input logic [W-1:0] d);
    res_t r;
    longint unsigned nn, dd, q, full;
    nn   = 64'(n);
    dd   = 64'(d);
    full = (64'd1 << W) - 64'd1;
    r.dz = 1'b0;
    r.ovf = 1'b0;
    if (d == 0) begin
      r.quot = '1; r.remo = n; r.sticky = (n != 0); r.dz = 1'b1;
    end else if (m) begin
      r.quot = W'(nn / dd); r.remo = W'(nn % dd); r.sticky = (nn % dd) != 0;
    end else if (n > d) begin
      r.quot = W'(full >> 1); r.remo = '0; r.sticky = 1'b1; r.ovf = 1'b1;
    end else begin
      q = (nn << W) / dd;
      if (q > full) q = full;
      r.quot = W'(q >> 1);
      r.remo = W'((nn << W) - q * dd);
      r.sticky = (r.remo != 0);
    end
    return r;
  endfunction

  task automatic chk_res(input string tag, input res_t a, input res_t e, input int lat, input int elat);
    chk({tag, " quot"}, 64'(a.quot), 64'(e.quot));
    chk({tag, " remo"}, 64'(a.remo), 64'(e.remo));
    chk({tag, " sticky"}, 64'(a.sticky), 64'(e.sticky));
    chk({tag, " div_zero"}, 64'(a.dz), 64'(e.dz));
    chk({tag, " ovf"}, 64'(a.ovf), 64'(e.ovf));
    chk({tag, " latency"}, 64'(lat), 64'(elat));
  endtask

  // One transaction on both instances; enters and leaves at a negedge.
  task automatic run_txn(input logic m, input logic [W-1:0] n, input logic [W-1:0] d,
                         input res_t e, input int stall);
    int   lat1, lat2;
    res_t c1, c2;
    lat1 = 0; lat2 = 0;
    c1 = '{default: '0}; c2 = '{default: '0};
    chk("in_ready b1 pre", 64'(bus1.in_ready), 64'd1);
    chk("in_ready b2 pre", 64'(bus2.in_ready), 64'd1);
    in_valid = 1'b1; mode_int = m; num = n; den = d;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 40 && (lat1 == 0 || lat2 == 0); c++) begin
      if (lat1 == 0 && bus1.out_valid) begin
        lat1 = c;
        c1 = '{bus1.quot, bus1.remo, bus1.sticky, bus1.div_zero, bus1.ovf};
      end
      if (lat2 == 0 && bus2.out_valid) begin
        lat2 = c;
        c2 = '{bus2.quot, bus2.remo, bus2.sticky, bus2.div_zero, bus2.ovf};
      end
      if (lat1 == 0 || lat2 == 0) @(negedge clk);
    end
    chk_res("b1", c1, e, lat1, (d == 0) ? 1 : LAT1);
    chk_res("b2", c2, e, lat2, (d == 0) ? 1 : LAT2);
    for (int s = 0; s < stall; s++) begin
      in_valid = s[0];
      num = ~n;
      den = d + W'(1);
      @(negedge clk);
      chk("stall out_valid b1", 64'(bus1.out_valid), 64'd1);
      chk("stall out_valid b2", 64'(bus2.out_valid), 64'd1);
      chk("stall in_ready b1", 64'(bus1.in_ready), 64'd0);
      chk("stall in_ready b2", 64'(bus2.in_ready), 64'd0);
      chk("stall quot b1", 64'(bus1.quot), 64'(e.quot));
      chk("stall remo b2", 64'(bus2.remo), 64'(e.remo));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release in_ready b1", 64'(bus1.in_ready), 64'd1);
    chk("release in_ready b2", 64'(bus2.in_ready), 64'd1);
    chk("release out_valid b1", 64'(bus1.out_valid), 64'd0);
    chk("release out_valid b2", 64'(bus2.out_valid), 64'd0);
  endtask

  vec_t vecs[12];

  initial begin
    logic         seen;
    logic         rm;
    logic [W-1:0] rn, rd;
    int unsigned  sel;

    vecs[0]  = '{1'b0, 26'h1000000, 26'h2000000, '{26'h1000000, 26'h0,      1'b0, 1'b0, 1'b0}};
    vecs[1]  = '{1'b0, 26'h1,       26'h3,       '{26'h0AAAAAA, 26'h1,      1'b1, 1'b0, 1'b0}};
    vecs[2]  = '{1'b1, 26'd1000,    26'd7,       '{26'd142,     26'd6,      1'b1, 1'b0, 1'b0}};
    vecs[3]  = '{1'b0, 26'd5,       26'd0,       '{26'h3FFFFFF, 26'd5,      1'b1, 1'b1, 1'b0}};
    vecs[4]  = '{1'b0, 26'd9,       26'd4,       '{26'h1FFFFFF, 26'h0,      1'b1, 1'b0, 1'b1}};
    vecs[5]  = '{1'b0, 26'h123,     26'h123,     '{26'h1FFFFFF, 26'h123,    1'b1, 1'b0, 1'b0}};
    vecs[6]  = '{1'b1, 26'd0,       26'd5,       '{26'd0,       26'd0,      1'b0, 1'b0, 1'b0}};
    vecs[7]  = '{1'b1, 26'h3FFFFFF, 26'd1,       '{26'h3FFFFFF, 26'd0,      1'b0, 1'b0, 1'b0}};
    vecs[8]  = '{1'b1, 26'd0,       26'd0,       '{26'h3FFFFFF, 26'd0,      1'b0, 1'b1, 1'b0}};
    vecs[9]  = '{1'b0, 26'd0,       26'd7,       '{26'd0,       26'd0,      1'b0, 1'b0, 1'b0}};
    vecs[10] = '{1'b1, 26'd5,       26'd9,       '{26'd0,       26'd5,      1'b1, 1'b0, 1'b0}};
    vecs[11] = '{1'b0, 26'd3,       26'd4,       '{26'h1800000, 26'd0,      1'b0, 1'b0, 1'b0}};

    rst = 1'b0; in_valid = 1'b0; mode_int = 1'b0; out_ready = 1'b0; num = '0; den = '0;
    repeat (2) @(negedge clk);
    chk("reset in_ready b1", 64'(bus1.in_ready), 64'd1);
    chk("reset in_ready b2", 64'(bus2.in_ready), 64'd1);
    chk("reset out_valid b1", 64'(bus1.out_valid), 64'd0);
    chk("reset out_valid b2", 64'(bus2.out_valid), 64'd0);
    chk("reset outs b1", 64'({bus1.quot, bus1.remo, bus1.sticky, bus1.div_zero, bus1.ovf}), 64'd0);
    chk("reset outs b2", 64'({bus2.quot, bus2.remo, bus2.sticky, bus2.div_zero, bus2.ovf}), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_txn(vecs[i].mode, vecs[i].num, vecs[i].den, vecs[i].exp, 0);

    // Consumer stall with in_valid pulses that must be ignored.
    run_txn(1'b0, 26'd1, 26'd3, model(1'b0, 26'd1, 26'd3), 10);

    // Reset mid-run aborts; no result appears afterwards.
    in_valid = 1'b1; mode_int = 1'b0; num = 26'd1; den = 26'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort in_ready b1", 64'(bus1.in_ready), 64'd1);
    chk("abort in_ready b2", 64'(bus2.in_ready), 64'd1);
    chk("abort out_valid b1", 64'(bus1.out_valid), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      seen = seen | bus1.out_valid | bus2.out_valid;
    end
    chk("abort no result", 64'(seen), 64'd0);
    run_txn(1'b1, 26'd1000, 26'd7, model(1'b1, 26'd1000, 26'd7), 0);

    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 9);
      rm  = 1'($urandom_range(0, 1));
      if (sel == 0)      rd = '0;
      else if (sel < 4)  rd = W'($urandom_range(1, 255));
      else               rd = W'($urandom);
      if (rm == 1'b0 && sel != 9 && rd != 0)
        rn = W'(64'($urandom) % (64'(rd) + 64'd1));
      else
        rn = W'($urandom);
      run_txn(rm, rn, rd, model(rm, rn, rd), (sel == 5) ? 2 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
